// File: rtl/b01_pkg.sv
// Shared types and default sizes for the b01 serial result collector.
package b01_pkg;

  localparam int unsigned B01_WIDTH = 8;
  localparam int unsigned B01_CNT_W = 8;

  // IDLE: no bits of the current word held; COLLECT: 1..WIDTH-1 bits held.
  typedef enum logic {
    B01_IDLE    = 1'b0,
    B01_COLLECT = 1'b1
  } b01_state_e;

endpackage

// File: rtl/b01_stream_collector_if.sv
// Serial input, word output handshake and status bundle of the b01 collector.
interface b01_stream_collector_if
  import b01_pkg::*;
#(
  parameter int unsigned WIDTH = B01_WIDTH,
  parameter int unsigned CNT_W = B01_CNT_W
);

  logic             bit_valid;
  logic             outp;
  logic             overflw;
  logic             clr;
  logic [WIDTH-1:0] word_data;
  logic             word_ovf;
  logic             word_valid;
  logic             word_ready;
  logic [CNT_W-1:0] ovf_count;
  logic             lost;

  // Environment side: produces the serial stream and consumes words.
  modport master (
    output bit_valid, outp, overflw, clr, word_ready,
    input  word_data, word_ovf, word_valid, ovf_count, lost
  );

  // Collector side.
  modport slave (
    input  bit_valid, outp, overflw, clr, word_ready,
    output word_data, word_ovf, word_valid, ovf_count, lost
  );

endinterface

// File: rtl/b01_word_hold.sv
// One-entry valid/ready holding register; a load while full and stalled is dropped.
module b01_word_hold #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_ovf,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             ovf,
  output logic             drop_c
);

  logic take_c;

  // Accept a new word when empty or when the held word leaves this cycle.
  assign take_c = load & (~valid | ready);
  assign drop_c = load & valid & ~ready;

  // Holding register; data stays put until replaced.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
      ovf   <= 1'b0;
    end else if (take_c) begin
      valid <= 1'b1;
      data  <= load_data;
      ovf   <= load_ovf;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/b01_stream_collector.sv
// Deserialises the b01 outp stream LSB-first into words with an overflow tag.
module b01_stream_collector
  import b01_pkg::*;
#(
  parameter int unsigned WIDTH = B01_WIDTH,
  parameter int unsigned CNT_W = B01_CNT_W
) (
  input logic                   clock,
  input logic                   reset,
  b01_stream_collector_if.slave bus
);

  localparam int unsigned   CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  b01_state_e       state_q, state_d;
  logic [CW-1:0]    bit_cnt_q;
  logic [WIDTH-1:0] shift_q;
  logic             povf_q;
  logic [CNT_W-1:0] ovf_count_q;
  logic             lost_q;

  logic             accept_c;
  logic             complete_c;
  logic [WIDTH-1:0] new_word_c;
  logic             new_ovf_c;
  logic             drop_c;
  logic             hold_valid;
  logic [WIDTH-1:0] hold_data;
  logic             hold_ovf;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= B01_IDLE;
    else       state_q <= state_d;
  end

  // Next state: leave COLLECT on flush or when the last bit of a word lands.
  always_comb begin
    state_d = state_q;
    case (state_q)
      B01_IDLE:    if (accept_c) state_d = B01_COLLECT;
      B01_COLLECT: if (bus.clr || complete_c) state_d = B01_IDLE;
      default:     state_d = B01_IDLE;
    endcase
  end

  // FSM strobes: clr masks any bit offered in the same cycle.
  always_comb begin
    accept_c   = 1'b0;
    complete_c = 1'b0;
    accept_c   = bus.bit_valid & ~bus.clr;
    if (state_q == B01_COLLECT && bit_cnt_q == LAST) complete_c = accept_c;
  end

  // The last bit bypasses the shifter straight into the holding register.
  assign new_word_c = {bus.outp, shift_q[WIDTH-2:0]};
  assign new_ovf_c  = povf_q | bus.overflw;

  // Bit counter, shifter and partial overflow of the word in progress.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bit_cnt_q <= '0;
      shift_q   <= '0;
      povf_q    <= 1'b0;
    end else if (bus.clr || complete_c) begin
      bit_cnt_q <= '0;
      shift_q   <= '0;
      povf_q    <= 1'b0;
    end else if (accept_c) begin
      bit_cnt_q          <= bit_cnt_q + CW'(1);
      shift_q[bit_cnt_q] <= bus.outp;
      povf_q             <= povf_q | bus.overflw;
    end
  end

  // Saturating count of accepted overflow bits.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) ovf_count_q <= '0;
    else if (accept_c && bus.overflw && ovf_count_q != '1)
      ovf_count_q <= ovf_count_q + CNT_W'(1);
  end

  // Sticky record of any completed word that found the output stalled.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)       lost_q <= 1'b0;
    else if (drop_c) lost_q <= 1'b1;
  end

  b01_word_hold #(.WIDTH(WIDTH)) u_hold (
    .clock     (clock),
    .reset     (reset),
    .load      (complete_c),
    .load_data (new_word_c),
    .load_ovf  (new_ovf_c),
    .ready     (bus.word_ready),
    .valid     (hold_valid),
    .data      (hold_data),
    .ovf       (hold_ovf),
    .drop_c    (drop_c)
  );

  assign bus.word_valid = hold_valid;
  assign bus.word_data  = hold_data;
  assign bus.word_ovf   = hold_ovf;
  assign bus.ovf_count  = ovf_count_q;
  assign bus.lost       = lost_q;

endmodule

// File: tb/tb_b01_stream_collector.sv
// Directed plus random bench for b01_stream_collector against a word-level model.
module tb_b01_stream_collector;
  import b01_pkg::*;

  localparam int unsigned W = 8;

  logic clock = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  b01_stream_collector_if #(.WIDTH(W), .CNT_W(8)) bus8 ();
  b01_stream_collector_if #(.WIDTH(W), .CNT_W(2)) bus2 ();

  // Second instance sees the same stimulus; only its counter width differs.
  assign bus2.bit_valid  = bus8.bit_valid;
  assign bus2.outp       = bus8.outp;
  assign bus2.overflw    = bus8.overflw;
  assign bus2.clr        = bus8.clr;
  assign bus2.word_ready = bus8.word_ready;

  b01_stream_collector #(.WIDTH(W), .CNT_W(8)) dut8 (
    .clock (clock), .reset (reset), .bus (bus8)
  );
  b01_stream_collector #(.WIDTH(W), .CNT_W(2)) dut2 (
    .clock (clock), .reset (reset), .bus (bus2)
  );

  always #5 clock = ~clock;

  // Reference: list of bits gathered so far, the output slot and counters.
  int         m_n;
  logic [7:0] m_pw;
  bit         m_po;
  bit         m_hv;
  logic [7:0] m_hd;
  bit         m_ho;
  bit         m_lost;
  int         m_c8;
  int         m_c2;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_n = 0; m_pw = '0; m_po = 0;
    m_hv = 0; m_hd = '0; m_ho = 0;
    m_lost = 0; m_c8 = 0; m_c2 = 0;
  endtask

  task automatic model_edge(input bit bv, input bit o, input bit ov, input bit c, input bit rdy);
    bit         done;
    logic [7:0] w;
    bit         wo;
    done = 0; w = '0; wo = 0;
    if (bv && ov && !c) begin
      m_c8 = (m_c8 < 255) ? m_c8 + 1 : 255;
      m_c2 = (m_c2 < 3) ? m_c2 + 1 : 3;
    end
    if (c) begin
      m_n = 0; m_pw = '0; m_po = 0;
    end else if (bv) begin
      m_pw[m_n] = o;
      m_po = m_po | ov;
      m_n++;
      if (m_n == W) begin
        done = 1; w = m_pw; wo = m_po;
        m_n = 0; m_pw = '0; m_po = 0;
      end
    end
    if (done) begin
      if (!m_hv || rdy) begin
        m_hv = 1; m_hd = w; m_ho = wo;
      end else begin
        m_lost = 1;
      end
    end else if (m_hv && rdy) begin
      m_hv = 0;
    end
  endtask

  task automatic check_all(input string ph);
    chk_val({ph, ":valid"},  32'(bus8.word_valid), 32'(m_hv));
    chk_val({ph, ":data"},   32'(bus8.word_data),  32'(m_hd));
    chk_val({ph, ":ovf"},    32'(bus8.word_ovf),   32'(m_ho));
    chk_val({ph, ":lost"},   32'(bus8.lost),       32'(m_lost));
    chk_val({ph, ":cnt8"},   32'(bus8.ovf_count),  32'(m_c8));
    chk_val({ph, ":valid2"}, 32'(bus2.word_valid), 32'(m_hv));
    chk_val({ph, ":data2"},  32'(bus2.word_data),  32'(m_hd));
    chk_val({ph, ":lost2"},  32'(bus2.lost),       32'(m_lost));
    chk_val({ph, ":cnt2"},   32'(bus2.ovf_count),  32'(m_c2));
  endtask

  // Called at a falling edge: drive, clock once, model, check at next falling edge.
  task automatic step(input bit bv, input bit o, input bit ov, input bit c, input bit rdy);
    bus8.bit_valid  = bv;
    bus8.outp       = o;
    bus8.overflw    = ov;
    bus8.clr        = c;
    bus8.word_ready = rdy;
    @(posedge clock);
    model_edge(bv, o, ov, c, rdy);
    @(negedge clock);
    check_all("step");
  endtask

  task automatic send_word(input logic [7:0] w, input int ovf_bit, input bit rdy_last, input bit rdy_rest);
    for (int i = 0; i < 8; i++)
      step(1'b1, w[i], (i == ovf_bit), 1'b0, (i == 7) ? rdy_last : rdy_rest);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #1;
    check_all("rst");
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus8.bit_valid = 0; bus8.outp = 0; bus8.overflw = 0; bus8.clr = 0; bus8.word_ready = 0;
    model_reset();
    repeat (2) @(negedge clock);
    check_all("init");
    reset = 1'b0;

    // 1: plain word, single-cycle valid pulse one cycle after the last bit.
    send_word(8'h4D, -1, 1'b1, 1'b1);
    chk_val("t1_data",  32'(bus8.word_data), 32'h4D);
    chk_val("t1_valid", 32'(bus8.word_valid), 32'd1);
    chk_val("t1_ovf",   32'(bus8.word_ovf), 32'd0);
    step(0, 0, 0, 0, 1);
    chk_val("t1_gone",  32'(bus8.word_valid), 32'd0);

    // 2: overflow on bit 5 tags the word and bumps the counter.
    send_word(8'h4D, 5, 1'b1, 1'b1);
    chk_val("t2_ovf",   32'(bus8.word_ovf), 32'd1);
    chk_val("t2_cnt",   32'(bus8.ovf_count), 32'd1);
    step(0, 0, 0, 0, 1);

    // 3: stalled output drops the second word.
    send_word(8'hA5, -1, 1'b0, 1'b0);
    send_word(8'h3C, -1, 1'b0, 1'b0);
    chk_val("t3_data",  32'(bus8.word_data), 32'hA5);
    chk_val("t3_lost",  32'(bus8.lost), 32'd1);
    step(0, 0, 0, 0, 1);
    chk_val("t3_gone",  32'(bus8.word_valid), 32'd0);

    // 4: consume and completion on the same edge, nothing lost.
    do_reset();
    send_word(8'hA5, -1, 1'b0, 1'b0);
    chk_val("t4_first", 32'(bus8.word_data), 32'hA5);
    send_word(8'h3C, -1, 1'b1, 1'b0);
    chk_val("t4_second", 32'(bus8.word_data), 32'h3C);
    chk_val("t4_valid",  32'(bus8.word_valid), 32'd1);
    chk_val("t4_lost",   32'(bus8.lost), 32'd0);
    step(0, 0, 0, 0, 1);

    // 5: clr flushes a partial word and masks its own bit.
    step(1, 1, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    step(1, 1, 0, 0, 1);
    step(1, 1, 0, 1, 1);
    chk_val("t5_noword", 32'(bus8.word_valid), 32'd0);
    send_word(8'hFF, -1, 1'b1, 1'b1);
    chk_val("t5_data",   32'(bus8.word_data), 32'hFF);
    chk_val("t5_valid",  32'(bus8.word_valid), 32'd1);
    step(0, 0, 0, 0, 1);

    // 6: narrow counter saturates; asynchronous reset mid-word.
    do_reset();
    for (int i = 0; i < 6; i++) step(1, i[0], 1, 0, 1);
    chk_val("t6_sat2", 32'(bus2.ovf_count), 32'd3);
    chk_val("t6_cnt8", 32'(bus8.ovf_count), 32'd6);
    reset = 1'b1;
    model_reset();
    #1;
    chk_val("t6_async_cnt", 32'(bus2.ovf_count), 32'd0);
    check_all("async");
    @(negedge clock);
    reset = 1'b0;
    send_word(8'h96, -1, 1'b1, 1'b1);
    chk_val("t6_after", 32'(bus8.word_data), 32'h96);
    step(0, 0, 0, 0, 1);

    // Random traffic with stalls, flushes and overflow bits.
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) < 2), ($urandom_range(0, 39) == 0),
           1'($urandom_range(0, 1)));
      if (n == 1500) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
